// File: rtl/ss_division_lanes_top.sv
// Multi-lane stochastic divider: per-lane bitstreams drive a saturating up/down
// estimator of p_x/p_y, and output ones are counted over a sequenced run.
module ss_division_lanes_top #(
  parameter int WIDTH      = 8,
  parameter int LANES      = 1,
  parameter int STREAM_LEN = 256,
  parameter int WARMUP     = 0,
  parameter int CNT_W      = $clog2(STREAM_LEN * LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       x_input,
  input  logic [WIDTH-1:0]       y_input,
  input  logic [LANES*WIDTH-1:0] x_randnum,
  input  logic [LANES*WIDTH-1:0] y_randnum,
  input  logic [LANES*WIDTH-1:0] z_randnum,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       result,
  output logic [WIDTH-1:0]       est
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam int EXT_W = WIDTH + POP_W + 1;
  localparam int TOTAL = WARMUP + STREAM_LEN;
  localparam int CYC_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [WIDTH-1:0] EST_MID  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TOTAL - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                    state_r, state_s;
  logic [WIDTH-1:0]          x_lat_r, y_lat_r, est_r, est_next_s;
  logic [CNT_W-1:0]          acc_r, acc_next_s, result_r;
  logic [CYC_W-1:0]          cyc_r;
  logic                      busy_r, done_r, last_s, count_en_s;
  logic [POP_W-1:0]          x_pop_s, yz_pop_s, z_pop_s;
  logic signed [EXT_W-1:0]   est_sum_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign est    = est_r;

  assign last_s = (cyc_r == CYC_LAST);

  generate
    if (WARMUP == 0) begin : g_no_warm
      assign count_en_s = 1'b1;
    end else begin : g_warm
      assign count_en_s = (cyc_r >= CYC_W'(WARMUP));
    end
  endgenerate

  // Per-lane stream comparisons reduced to popcounts
  always_comb begin
    x_pop_s  = {POP_W{1'b0}};
    yz_pop_s = {POP_W{1'b0}};
    z_pop_s  = {POP_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      x_pop_s  = x_pop_s + POP_W'(x_randnum[i*WIDTH +: WIDTH] < x_lat_r);
      z_pop_s  = z_pop_s + POP_W'(z_randnum[i*WIDTH +: WIDTH] < est_r);
      yz_pop_s = yz_pop_s + POP_W'((y_randnum[i*WIDTH +: WIDTH] < y_lat_r) &&
                                   (z_randnum[i*WIDTH +: WIDTH] < est_r));
    end
  end

  // Estimator step with saturation; the extra bits keep the sum free of wrap
  always_comb begin
    est_sum_s = $signed({{(EXT_W-WIDTH){1'b0}}, est_r})
              + $signed({{(EXT_W-POP_W){1'b0}}, x_pop_s})
              - $signed({{(EXT_W-POP_W){1'b0}}, yz_pop_s});
    if (est_sum_s[EXT_W-1]) begin
      est_next_s = {WIDTH{1'b0}};
    end else if (|est_sum_s[EXT_W-2:WIDTH]) begin
      est_next_s = {WIDTH{1'b1}};
    end else begin
      est_next_s = est_sum_s[WIDTH-1:0];
    end
    if (count_en_s) begin
      acc_next_s = acc_r + CNT_W'(z_pop_s);
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Run sequencer next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (abort || last_s) state_s = IDLE;
        else                 state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {CNT_W{1'b0}};
      est_r    <= EST_MID;
      x_lat_r  <= {WIDTH{1'b0}};
      y_lat_r  <= {WIDTH{1'b0}};
      acc_r    <= {CNT_W{1'b0}};
      cyc_r    <= {CYC_W{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_r == RUN) && !abort && last_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            x_lat_r <= x_input;
            y_lat_r <= y_input;
            est_r   <= EST_MID;
            acc_r   <= {CNT_W{1'b0}};
            cyc_r   <= {CYC_W{1'b0}};
          end
        end
        RUN: begin
          if (!abort) begin
            est_r <= est_next_s;
            acc_r <= acc_next_s;
            cyc_r <= cyc_r + CYC_W'(1);
            if (last_s) result_r <= acc_next_s;
          end
        end
        default: begin
          est_r <= EST_MID;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_division_lanes_top.sv
// Randomized scoreboard bench for ss_division_lanes_top: a per-run arithmetic
// model predicts result/final estimate/done timing, a monitor checks on done.
module tb_ss_division_lanes_top;

  localparam int WIDTH      = 8;
  localparam int LANES      = 4;
  localparam int STREAM_LEN = 64;
  localparam int WARMUP     = 8;
  localparam int TOTAL      = WARMUP + STREAM_LEN;
  localparam int CNT_W      = $clog2(STREAM_LEN * LANES + 1);
  localparam int MID        = 1 << (WIDTH - 1);
  localparam int EMAX       = (1 << WIDTH) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start, abort;
  logic [WIDTH-1:0]       x_input, y_input;
  logic [LANES*WIDTH-1:0] x_randnum, y_randnum, z_randnum;
  logic                   busy, done;
  logic [CNT_W-1:0]       result;
  logic [WIDTH-1:0]       est;

  ss_division_lanes_top #(
    .WIDTH(WIDTH), .LANES(LANES), .STREAM_LEN(STREAM_LEN), .WARMUP(WARMUP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x_input(x_input), .y_input(y_input),
    .x_randnum(x_randnum), .y_randnum(y_randnum), .z_randnum(z_randnum),
    .busy(busy), .done(done), .result(result), .est(est)
  );

  always #5 clk = ~clk;

  typedef struct {int res; int est; int cyc;} exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int last_res = 0;
  int busy_len = 0;
  bit prev_done = 1'b0;

  logic [LANES*WIDTH-1:0] xr [TOTAL];
  logic [LANES*WIDTH-1:0] yr [TOTAL];
  logic [LANES*WIDTH-1:0] zr [TOTAL];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [LANES*WIDTH-1:0] rand_vec();
    logic [LANES*WIDTH-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom());
    return v;
  endfunction

  // Reference: probability-stream divider evaluated lane by lane on integers
  function automatic void model(input int x, input int y, output int res, output int est_f);
    int e, acc;
    e = MID;
    acc = 0;
    for (int k = 0; k < TOTAL; k++) begin
      int up, down, ones;
      up = 0; down = 0; ones = 0;
      for (int i = 0; i < LANES; i++) begin
        int xv, yv, zv;
        bit zb;
        xv = int'(xr[k][i*WIDTH +: WIDTH]);
        yv = int'(yr[k][i*WIDTH +: WIDTH]);
        zv = int'(zr[k][i*WIDTH +: WIDTH]);
        zb = (zv < e);
        if (xv < x) up++;
        if (zb) ones++;
        if (zb && (yv < y)) down++;
      end
      if (k >= WARMUP) acc += ones;
      e = e + up - down;
      if (e < 0) e = 0;
      if (e > EMAX) e = EMAX;
    end
    res = acc;
    est_f = e;
  endfunction

  // Monitor: pops the scoreboard whenever done is presented
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_len = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("result", int'(result), e.res);
          check("est_final", int'(est), e.est);
          check("done_latency", cyc_cnt, e.cyc);
          check("busy_len", busy_len, TOTAL);
          check("busy_at_done", int'(busy), 0);
        end
        if (prev_done) check("done_width", 2, 1);
      end
      busy_len = busy ? busy_len + 1 : 0;
      prev_done = done;
    end
  end

  task automatic run_op(input int x, input int y, input bit rnd, input int restart_at,
                        input int abort_at, input int rst_at, input bit idle_abort);
    exp_t e;
    int res, est_f;
    for (int k = 0; k < TOTAL; k++) begin
      xr[k] = rnd ? rand_vec() : {(LANES*WIDTH){1'b0}};
      yr[k] = rnd ? rand_vec() : {(LANES*WIDTH){1'b0}};
      zr[k] = rnd ? rand_vec() : {(LANES*WIDTH){1'b0}};
    end
    model(x, y, res, est_f);
    @(negedge clk);
    x_input = WIDTH'(x);
    y_input = WIDTH'(y);
    start   = 1'b1;
    abort   = idle_abort;
    if (abort_at < 0 && rst_at < 0) begin
      e.res = res;
      e.est = est_f;
      e.cyc = cyc_cnt + 1 + TOTAL;
      sb_q.push_back(e);
    end
    @(posedge clk);
    for (int k = 0; k < TOTAL; k++) begin
      @(negedge clk);
      start     = (k == restart_at);
      abort     = (k == abort_at);
      x_input   = WIDTH'($urandom());
      y_input   = WIDTH'($urandom());
      x_randnum = xr[k];
      y_randnum = yr[k];
      z_randnum = zr[k];
      if (k == 0) begin
        check("busy_in_run", int'(busy), 1);
        check("result_held_mid_run", int'(result), last_res);
      end
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_est", int'(est), MID);
        @(negedge clk);
        rst = 1'b1;
        last_res = 0;
        return;
      end
      @(posedge clk);
      if (k == abort_at) begin
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_result_kept", int'(result), last_res);
        return;
      end
    end
    last_res = res;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    x_input = {WIDTH{1'b0}};
    y_input = {WIDTH{1'b0}};
    x_randnum = {(LANES*WIDTH){1'b0}};
    y_randnum = {(LANES*WIDTH){1'b0}};
    z_randnum = {(LANES*WIDTH){1'b0}};
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_est", int'(est), MID);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(0,   255, 1'b0, -1, -1, -1, 1'b0);
    run_op(255, 255, 1'b0, -1, -1, -1, 1'b0);
    run_op(255, 0,   1'b0, -1, -1, -1, 1'b0);
    run_op(64,  128, 1'b1, -1, -1, -1, 1'b0);
    run_op(64,  128, 1'b1, 10, -1, -1, 1'b0);
    run_op(100, 200, 1'b1, -1, 50, -1, 1'b0);
    run_op(30,  90,  1'b1, -1, -1, -1, 1'b1);
    run_op(200, 220, 1'b1, -1, -1, 30, 1'b0);
    run_op(128, 255, 1'b1, -1, -1, -1, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             1'b1, -1, -1, -1, 1'b0);
    end

    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_division_lanes_top.md
Name: ss_division_lanes_top

Overview:
- Parametrised successor to the single-lane stochastic divider top. Generates LANES parallel stochastic bitstreams for x and y from binary operands and external random numbers.
- Divides using a Gaines-style saturating up/down estimator (p_z = p_x / p_y) and accumulates output ones over a programmable stream length.
- Adds a start/busy/done run sequencer, warm-up cycles, abort, and a held result.
- Sits between the random-number source and the result readout of the stochastic arithmetic datapath.

Parameters:
- WIDTH, 8, operand, random-number and estimator precision in bits.
- LANES, 1, stochastic bits processed per cycle; each lane has its own random numbers.
- STREAM_LEN, 256, counted RUN cycles per operation (>=1).
- WARMUP, 0, uncounted RUN cycles before counting starts; the estimator still updates.
- CNT_W, $clog2(STREAM_LEN*LANES+1), result width (derived).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  synchronous cancel of a run in progress
- x_input  in  WIDTH  dividend probability numerator (value/2^WIDTH)
- y_input  in  WIDTH  divisor probability numerator
- x_randnum  in  LANES*WIDTH  lane i uses bits [i*WIDTH +: WIDTH]
- y_randnum  in  LANES*WIDTH  per-lane random numbers for y
- z_randnum  in  LANES*WIDTH  per-lane random numbers for z
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the result becomes valid
- result  out  CNT_W  count of z ones over the counted cycles
- est  out  WIDTH  current estimator value (debug/verification)

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, est=2^(WIDTH-1), latched operands=0, cycle counter=0.
- States: IDLE, RUN. No other states.
- IDLE, start=1 at edge t:
  - latch x_input and y_input;
  - est<=2^(WIDTH-1); accumulator<=0; cycle counter<=0;
  - go to RUN; busy=1 from t+1.
- RUN stimulus is generated from the latched operands, so input changes during RUN have no effect.
- Stream generation, per lane i, combinational:
  - xb[i] = (x_rand_i < x_lat)
  - yb[i] = (y_rand_i < y_lat)
  - zb[i] = (z_rand_i < est)
  - all comparisons unsigned.
- Estimator update, each RUN cycle:
  - est <= clamp(est + popcount(xb) - popcount(yb & zb), 0, 2^WIDTH-1);
  - use a signed intermediate of WIDTH+$clog2(LANES+1)+1 bits; no wrap-around.
- Counting:
  - RUN cycle index k = 0 .. WARMUP+STREAM_LEN-1;
  - for k >= WARMUP, accumulator += popcount(zb) using the pre-update est.
- After the cycle with k = WARMUP+STREAM_LEN-1:
  - result <= final accumulator; done=1 for exactly one cycle;
  - busy=0; state=IDLE.
- result holds its value until the next completed run. It does not change on start, abort, or mid-run.
- start while in RUN is ignored. start in the same cycle as done=1 is accepted (state is already IDLE).
- abort=1 in RUN: return to IDLE next edge, busy=0, no done, result unchanged. abort is ignored in IDLE. If start and abort are both high in IDLE, start wins.
- Edge cases:
  - y_lat=0: est climbs and saturates at 2^WIDTH-1.
  - x_lat > y_lat: est saturates high.
  - x_lat=0: est decays to 0 and saturates.
- Latency from start to done: WARMUP+STREAM_LEN+1 cycles.
- Reset asserted mid-run aborts immediately to reset values; result is cleared to 0.

Test Plan:
- WIDTH=8, LANES=1, STREAM_LEN=256, all randnums=0, x=0, y=255, start pulse → est falls 128→0 and stays 0; done exactly 257 cycles after start; result=128.
- Same config, x=255, y=255, randnums=0 → est constant 128; result=256; busy high exactly 256 cycles.
- Same config, x=255, y=0, randnums=0 → est rises to 255 by cycle 127, saturates with no wrap to 0; result=256.
- LANES=4, STREAM_LEN=1024, WARMUP=64, independent 8-bit LFSRs per lane, x=64, y=128 → result matches a bit-exact reference model; value ≈2048±200; est hovers near 128.
- Handshake: start again 10 cycles into RUN → ignored, single done pulse. abort at cycle 50 → busy drops, no done, previous result retained. start on the done cycle → new run begins immediately.
- Drive rst=0 asynchronously mid-run → busy, done, result and est go to 0/0/0/128 without waiting for a clock edge; next start runs normally.
